// File: rtl/sram_arbiter.sv
// Two-port arbiter/sequencer sharing one single-ported byte-addressed SRAM between
// instruction fetch (read-only) and data memory (read/write with byte strobes).
module sram_arbiter #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned PRIO_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,

  input  logic              dm_req,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [3:0]        dm_wstrb,
  input  logic [31:0]       dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [31:0]       dm_rdata,

  output logic [ADDR_W-1:0] sram_address,
  output logic [3:0]        sram_w_en,
  output logic [31:0]       sram_write_data,
  input  logic [31:0]       sram_read_data,

  output logic              busy
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StAcc  = 2'b01,
    StDone = 2'b10
  } state_e;

  state_e              r_state;
  state_e              w_state_next;

  logic [ADDR_W-1:0]   r_addr;
  logic [3:0]          r_wstrb;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rdata;
  logic                r_owner_dm;
  logic                r_last_dm;

  logic                w_accept;
  logic                w_tie_dm;
  logic                w_dm_win;
  logic                w_if_win;
  logic                w_if_gnt;
  logic                w_dm_gnt;

  // Arbitration: a lone requester wins; on a tie, fixed dm priority or the port not granted last.
  always_comb begin
    w_accept = (r_state == StIdle) || (r_state == StDone);
    w_tie_dm = (PRIO_MODE == 1) ? 1'b1 : ~r_last_dm;
    w_dm_win = dm_req & (~if_req | w_tie_dm);
    w_if_win = if_req & ~w_dm_win;
    w_dm_gnt = rst_n & w_accept & w_dm_win;
    w_if_gnt = rst_n & w_accept & w_if_win;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = StIdle;
    unique case (r_state)
      StIdle, StDone: w_state_next = (w_if_gnt | w_dm_gnt) ? StAcc : StIdle;
      StAcc:          w_state_next = StDone;
      default:        w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_wstrb    <= '0;
      r_wdata    <= '0;
      r_owner_dm <= 1'b0;
      r_last_dm  <= 1'b0;
    end else if (w_dm_gnt) begin
      r_addr     <= dm_addr;
      r_wstrb    <= dm_wstrb;
      r_wdata    <= dm_wdata;
      r_owner_dm <= 1'b1;
      r_last_dm  <= 1'b1;
    end else if (w_if_gnt) begin
      // Fetches never write; write data keeps its last latched value.
      r_addr     <= if_addr;
      r_wstrb    <= '0;
      r_owner_dm <= 1'b0;
      r_last_dm  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (r_state == StAcc) begin
      r_rdata <= sram_read_data;
    end
  end

  always_comb begin
    if_gnt          = w_if_gnt;
    dm_gnt          = w_dm_gnt;
    busy            = (r_state == StAcc);
    sram_address    = r_addr;
    sram_write_data = r_wdata;
    sram_w_en       = (r_state == StAcc) ? r_wstrb : 4'b0000;
    if_rvalid       = (r_state == StDone) & ~r_owner_dm;
    dm_rvalid       = (r_state == StDone) & r_owner_dm;
    if_rdata        = r_rdata;
    dm_rdata        = r_rdata;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: fetch read, strobed write/read-back, tie arbitration in both
// priority modes, reset during an access and address wrap.
module tb_sram_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic [15:0] dm_addr;
  logic [3:0]  dm_wstrb;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic [15:0] sram_address;
  logic [3:0]  sram_w_en;
  logic [31:0] sram_write_data;
  logic [31:0] sram_read_data;
  logic        busy;

  // Second instance in fixed-priority mode; its SRAM is not modelled.
  logic        p_if_req;
  logic        p_dm_req;
  logic        p_if_gnt;
  logic        p_dm_gnt;
  logic        p_if_rvalid;
  logic        p_dm_rvalid;
  logic [31:0] p_if_rdata;
  logic [31:0] p_dm_rdata;
  logic [15:0] p_sram_address;
  logic [3:0]  p_sram_w_en;
  logic [31:0] p_sram_write_data;
  logic        p_busy;

  logic [7:0]  mem [0:65535];
  int          n_checks;
  int          n_errors;

  sram_arbiter #(.ADDR_W(16), .PRIO_MODE(0)) u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .if_req          (if_req),
    .if_addr         (if_addr),
    .if_gnt          (if_gnt),
    .if_rvalid       (if_rvalid),
    .if_rdata        (if_rdata),
    .dm_req          (dm_req),
    .dm_addr         (dm_addr),
    .dm_wstrb        (dm_wstrb),
    .dm_wdata        (dm_wdata),
    .dm_gnt          (dm_gnt),
    .dm_rvalid       (dm_rvalid),
    .dm_rdata        (dm_rdata),
    .sram_address    (sram_address),
    .sram_w_en       (sram_w_en),
    .sram_write_data (sram_write_data),
    .sram_read_data  (sram_read_data),
    .busy            (busy)
  );

  sram_arbiter #(.ADDR_W(16), .PRIO_MODE(1)) u_dut_prio (
    .clk             (clk),
    .rst_n           (rst_n),
    .if_req          (p_if_req),
    .if_addr         (16'h0010),
    .if_gnt          (p_if_gnt),
    .if_rvalid       (p_if_rvalid),
    .if_rdata        (p_if_rdata),
    .dm_req          (p_dm_req),
    .dm_addr         (16'h0020),
    .dm_wstrb        (4'b0000),
    .dm_wdata        (32'h0),
    .dm_gnt          (p_dm_gnt),
    .dm_rvalid       (p_dm_rvalid),
    .dm_rdata        (p_dm_rdata),
    .sram_address    (p_sram_address),
    .sram_w_en       (p_sram_w_en),
    .sram_write_data (p_sram_write_data),
    .sram_read_data  (32'h0),
    .busy            (p_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-addressed SRAM model: combinational read with 16-bit wrap, byte-lane write at the edge.
  assign sram_read_data = {mem[sram_address + 16'd3], mem[sram_address + 16'd2],
                           mem[sram_address + 16'd1], mem[sram_address]};

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    mem[16'h0010] = 8'h11; mem[16'h0011] = 8'h22; mem[16'h0012] = 8'h33; mem[16'h0013] = 8'h44;
    mem[16'hFFFE] = 8'h5A; mem[16'hFFFF] = 8'h6B; mem[16'h0000] = 8'h7C; mem[16'h0001] = 8'h8D;
    forever begin
      @(posedge clk);
      if (sram_w_en[0]) mem[sram_address]          <= sram_write_data[7:0];
      if (sram_w_en[1]) mem[sram_address + 16'd1] <= sram_write_data[15:8];
      if (sram_w_en[2]) mem[sram_address + 16'd2] <= sram_write_data[23:16];
      if (sram_w_en[3]) mem[sram_address + 16'd3] <= sram_write_data[31:24];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] e_dm_gnt;
  logic [7:0] e_if_gnt;
  logic [7:0] e_dm_rv;
  logic [7:0] e_if_rv;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    if_req   = 1'b0;
    if_addr  = 16'h0;
    dm_req   = 1'b0;
    dm_addr  = 16'h0;
    dm_wstrb = 4'h0;
    dm_wdata = 32'h0;
    p_if_req = 1'b0;
    p_dm_req = 1'b0;

    // Reset state
    #2;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_sram_addr", {16'h0, sram_address}, 32'h0);
    chk("rst_w_en", {28'h0, sram_w_en}, 32'h0);
    chk("rst_wdata", sram_write_data, 32'h0);
    chk("rst_rvalids", {30'h0, if_rvalid, dm_rvalid}, 32'h0);
    chk("rst_rdata", if_rdata, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Fetch read: gnt at N, address at N+1, rvalid/rdata at N+2
    if_req  = 1'b1;
    if_addr = 16'h0010;
    #1;
    chk("if_gnt_N", {30'h0, if_gnt, dm_gnt}, 32'h2);
    tick();
    if_req  = 1'b0;
    if_addr = 16'hDEAD;
    #1;
    chk("if_acc_addr", {16'h0, sram_address}, 32'h0010);
    chk("if_acc_busy_gnt", {30'h0, busy, if_gnt}, 32'h2);
    chk("if_acc_w_en", {28'h0, sram_w_en}, 32'h0);
    tick();
    chk("if_done_rvalid", {30'h0, if_rvalid, dm_rvalid}, 32'h2);
    chk("if_done_rdata", if_rdata, 32'h44332211);
    tick();

    // Strobed write then read-back
    dm_req   = 1'b1;
    dm_addr  = 16'h0020;
    dm_wstrb = 4'b0101;
    dm_wdata = 32'hAABBCCDD;
    #1;
    chk("wr_gnt", {30'h0, if_gnt, dm_gnt}, 32'h1);
    tick();
    dm_req   = 1'b0;
    dm_wstrb = 4'b1111;
    dm_wdata = 32'h12345678;
    #1;
    chk("wr_acc_w_en", {28'h0, sram_w_en}, 32'h5);
    chk("wr_acc_wdata", sram_write_data, 32'hAABBCCDD);
    chk("wr_acc_addr", {16'h0, sram_address}, 32'h0020);
    tick();
    chk("wr_done_w_en", {28'h0, sram_w_en}, 32'h0);
    chk("wr_done_rvalid", {30'h0, if_rvalid, dm_rvalid}, 32'h1);
    chk("wr_done_rdata_old", dm_rdata, 32'h0);
    dm_req   = 1'b1;
    dm_wstrb = 4'b0000;
    #1;
    chk("rd_gnt_in_done", {31'h0, dm_gnt}, 32'h1);
    tick();
    dm_req = 1'b0;
    #1;
    chk("rd_acc_w_en", {28'h0, sram_w_en}, 32'h0);
    tick();
    chk("rd_done_rvalid", {31'h0, dm_rvalid}, 32'h1);
    chk("rd_done_rdata", dm_rdata, 32'h00BB00DD);
    tick();
    chk("idle_after_done", {30'h0, busy, dm_rvalid}, 32'h0);

    // Reset during the ACC cycle of a fetch
    if_req  = 1'b1;
    if_addr = 16'h0010;
    #1;
    chk("rst_mid_gnt", {31'h0, if_gnt}, 32'h1);
    tick();
    if_req = 1'b0;
    #1;
    chk("rst_mid_busy", {31'h0, busy}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy0", {31'h0, busy}, 32'h0);
    chk("rst_mid_addr0", {16'h0, sram_address}, 32'h0);
    chk("rst_mid_rdata0", if_rdata, 32'h0);
    chk("rst_mid_misc0", {26'h0, if_rvalid, dm_rvalid, sram_w_en}, 32'h0);
    tick();
    chk("rst_mid_no_rvalid", {30'h0, if_rvalid, dm_rvalid}, 32'h0);
    rst_n = 1'b1;
    #1;

    // Both ports requesting continuously: round-robin vs fixed dm priority
    e_dm_gnt = 8'b0001_0001;
    e_if_gnt = 8'b0100_0100;
    e_dm_rv  = 8'b0100_0100;
    e_if_rv  = 8'b0001_0000;
    for (int i = 0; i < 8; i++) begin
      if_req   = 1'b1;
      if_addr  = 16'h0010;
      dm_req   = 1'b1;
      dm_addr  = 16'h0020;
      dm_wstrb = 4'b0000;
      p_if_req = 1'b1;
      p_dm_req = 1'b1;
      #1;
      chk($sformatf("tie_dm_gnt_%0d", i), {31'h0, dm_gnt}, {31'h0, e_dm_gnt[i]});
      chk($sformatf("tie_if_gnt_%0d", i), {31'h0, if_gnt}, {31'h0, e_if_gnt[i]});
      chk($sformatf("tie_dm_rv_%0d", i), {31'h0, dm_rvalid}, {31'h0, e_dm_rv[i]});
      chk($sformatf("tie_if_rv_%0d", i), {31'h0, if_rvalid}, {31'h0, e_if_rv[i]});
      chk($sformatf("tie_one_gnt_%0d", i), {31'h0, if_gnt & dm_gnt}, 32'h0);
      chk($sformatf("prio_dm_gnt_%0d", i), {31'h0, p_dm_gnt}, {31'h0, ~i[0]});
      chk($sformatf("prio_if_gnt_%0d", i), {31'h0, p_if_gnt}, 32'h0);
      if (e_dm_rv[i]) chk($sformatf("tie_dm_rdata_%0d", i), dm_rdata, 32'h00BB00DD);
      if (e_if_rv[i]) chk($sformatf("tie_if_rdata_%0d", i), if_rdata, 32'h44332211);
      tick();
    end
    if_req   = 1'b0;
    dm_req   = 1'b0;
    p_if_req = 1'b0;
    p_dm_req = 1'b0;
    #1;
    chk("tie_last_if_rv", {30'h0, if_rvalid, dm_rvalid}, 32'h2);
    chk("tie_last_rdata", if_rdata, 32'h44332211);
    chk("tie_no_gnt", {29'h0, if_gnt, dm_gnt, p_dm_gnt}, 32'h0);
    tick();

    // Read straddling the top of the address space
    dm_req   = 1'b1;
    dm_addr  = 16'hFFFE;
    dm_wstrb = 4'b0000;
    #1;
    chk("wrap_gnt", {31'h0, dm_gnt}, 32'h1);
    tick();
    dm_req = 1'b0;
    #1;
    chk("wrap_addr", {16'h0, sram_address}, 32'hFFFE);
    tick();
    chk("wrap_rvalid", {31'h0, dm_rvalid}, 32'h1);
    chk("wrap_rdata", dm_rdata, 32'h8D7C6B5A);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter and sequencer in front of the single-ported byte-addressed `SRAM`. It shares that SRAM between the instruction-fetch port (`if_*`, read-only) and the data-memory port (`dm_*`, read/write with byte strobes). It accepts one request at a time and drives the SRAM address, byte write enables and write data for exactly one cycle per access. It returns the sampled 32-bit read word with a one-cycle valid pulse. It sits between the CPU core's fetch/LSU stages and the SRAM macro.

## Interface
- `ADDR_W`, default 16: byte-address width, matching the SRAM address port.
- `PRIO_MODE`, default 0: arbitration policy on a tie.
  - 0 = round-robin.
  - 1 = fixed priority, `dm` wins.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request; held with `if_addr` until `if_gnt`.
- `if_addr`  in  ADDR_W  fetch byte address.
- `if_gnt`  out  1  fetch request accepted this cycle (combinational).
- `if_rvalid`  out  1  one-cycle pulse; `if_rdata` valid.
- `if_rdata`  out  32  read word `{mem[a+3],mem[a+2],mem[a+1],mem[a]}`.
- `dm_req`  in  1  data request; held with addr/strb/wdata until `dm_gnt`.
- `dm_addr`  in  ADDR_W  data byte address.
- `dm_wstrb`  in  4  byte write strobes; 0 = read.
- `dm_wdata`  in  32  write data, lane i = bits [8i+7:8i].
- `dm_gnt`  out  1  data request accepted this cycle (combinational).
- `dm_rvalid`  out  1  one-cycle completion pulse, for both reads and writes.
- `dm_rdata`  out  32  read word (pre-write contents on a write).
- `sram_address`  out  ADDR_W  to SRAM `address`.
- `sram_w_en`  out  4  to SRAM `w_en`.
- `sram_write_data`  out  32  to SRAM `write_data`.
- `sram_read_data`  in  32  from SRAM `read_data` (combinational, same cycle).
- `busy`  out  1  high in ACC.

## Operation
- States: IDLE, ACC, DONE. Encoded in 2 bits; the unused encoding goes to IDLE.
- Acceptance happens only in IDLE or DONE.
  - If any `req` is high, assert the winner's `gnt`, latch its addr/strb/wdata and owner ID, and go to ACC.
  - With no request, IDLE stays IDLE and DONE goes to IDLE.
- ACC lasts exactly one cycle.
  - `sram_address` = latched address.
  - `sram_w_en` = latched strobes (always 0 for `if`).
  - `sram_write_data` = latched wdata.
  - The rdata register captures `sram_read_data` at the closing edge.
  - Next state is DONE.
- DONE: the owner's `rvalid` = 1 and the shared rdata register drives both `if_rdata` and `dm_rdata`. A new request may be accepted in the same cycle.
- Outside ACC, `sram_w_en` = 0. `sram_address` and `sram_write_data` hold their last latched values.
- Arbitration:
  - PRIO_MODE=0: on a tie, grant the port not granted last. The `last` flag resets to `if`, so the first tie goes to `dm`.
  - PRIO_MODE=1: `dm` always wins a tie.
  - A single requester always wins.
- At most one `gnt` is high per cycle. `gnt` is never high in ACC.
- `req` may drop before `gnt` without side effects. After `gnt`, the requester may change its inputs immediately.
- No alignment checks. The address is forwarded unchanged, and the SRAM wraps `a+1..a+3` modulo 2^ADDR_W.

## Timing
- Reset (`rst_n` low, asynchronous):
  - state = IDLE, `last` = `if`.
  - All outputs 0: gnts, rvalids, `busy`, `sram_w_en`, `sram_address`, `sram_write_data`, rdata register.
- Reset mid-operation: the in-flight access is dropped with no `rvalid`. A write in ACC may or may not have committed.
- Latency: `gnt` in cycle N, ACC in N+1, `rvalid` in N+2.
- Peak throughput: one access per 2 cycles (DONE overlaps the next accept).
- Write commit: at the rising edge ending ACC. A read of the same address accepted in that DONE returns the new data.

## Test plan
- Reset, then `if_req` with `if_addr`=0x0010 and mem[0x10..0x13]=11,22,33,44:
  - `if_gnt` at N.
  - `sram_address`=0x0010 at N+1.
  - `if_rvalid` at N+2 with `if_rdata`=0x44332211.
- `dm` write: addr 0x0020, wstrb 4'b0101, wdata 0xAABBCCDD.
  - `sram_w_en`=0101 for exactly 1 cycle.
  - A following `dm` read returns 0x00BB00DD from zeroed memory.
- Both `req` held high for 8 cycles with PRIO_MODE=0:
  - Grants go dm, if, dm, if.
  - One `rvalid` every 2 cycles to the matching port.
  - Never two gnts in one cycle.
- Same stimulus with PRIO_MODE=1: `dm_gnt` on every accept, `if_gnt` never.
- Assert `rst_n`=0 during ACC of a read:
  - All outputs are 0 immediately and there is no `rvalid`.
  - After release, the first tie grants `dm`.
- `dm` read at 0xFFFE: the bytes come from 0xFFFE, 0xFFFF, 0x0000, 0x0001 (wrap).
